m2_block_writer: RTL and testbench
==================================

Name: m2_block_writer

Overview:
Write-back end of the Milestone 2 datapath. It reads one finished 8x8 block of 64 signed 32-bit samples from a dual-port embedded RAM read port and clips each sample to 8 bits. It packs the samples two per 16-bit word and writes the 32 words into SRAM at the block's position in a 320x240 plane. It is the counterpart of the block fetcher that loads SRAM pixels into embedded RAM.

Parameters:
BASE_ADDR, 18'd0, SRAM word address of plane pixel (0,0)
ROW_STRIDE, 160, SRAM words per image row (320 pixels / 2)
RAM_BASE, 7'd0, embedded-RAM address of block sample 0
MAX_BROW, 29, largest legal block_row
MAX_BCOL, 39, largest legal block_col

Ports:
Clock  in  1  system clock
Resetn  in  1  asynchronous active-low reset
Start  in  1  one-cycle request; samples block_row/block_col
block_row  in  5  block row index, 0..MAX_BROW
block_col  in  6  block column index, 0..MAX_BCOL
Done  out  1  one-cycle pulse when the last SRAM write has been issued
Busy  out  1  high from the cycle after accepted Start until Done
ram_address  out  7  embedded-RAM read address (port a)
ram_read_data  in  32  signed sample, valid 1 cycle after its address
SRAM_address  out  18  SRAM word address
SRAM_write_data  out  16  packed pixel pair
SRAM_we_n  out  1  SRAM write enable, active low

Behaviour:
- Reset: Resetn is asynchronous and active-low; the clock is Clock. Reset drives state IDLE, Done=0, Busy=0, ram_address=RAM_BASE, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, and clears all counters and the even-pixel latch. All outputs are registered.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - Start=1 latches block_row and block_col, sets k=0 and goes to READ.
  - Start is ignored in every other state.
- READ:
  - Each cycle drives ram_address=RAM_BASE+k, then k++.
  - After k=63 has been issued, the next state is DRAIN.
- Data stage: sample k returns one cycle after its address.
  - Clip as signed: value<0 gives 0; value>255 gives 255; otherwise bits [7:0].
  - Even k: the clipped byte is latched.
  - Odd k: on the next edge, SRAM_write_data={even_byte, odd_byte} and SRAM_we_n=0 for exactly that cycle.
  - SRAM_we_n is 1 in all other cycles.
- Address for the word holding samples k-1,k (k odd), with r=k>>3 and c=(k&7)>>1:
  - SRAM_address = BASE_ADDR + (block_row*8 + r)*ROW_STRIDE + block_col*4 + c.
  - Implement with a registered row-base accumulator: add ROW_STRIDE each time r increments. No multiplier is used at run time.
  - The start row base is computed once at Start acceptance (shift-add permitted).
- DRAIN: one cycle that finishes data for k=63 and its write.
- DONE: Done=1 for one cycle, Busy falls in the same cycle, then the state returns to IDLE.
- Latency: Start accepted at cycle 0.
  - ram_address for sample 0 appears in cycle 1.
  - The first write (SRAM_we_n=0) appears in cycle 3.
  - Writes follow every 2 cycles; the last write appears in cycle 65.
  - Done appears in cycle 66.
  - A new Start is accepted in the cycle Done is high or later.
- Reset mid-operation: return to IDLE immediately with SRAM_we_n=1. No partial word is written and no Done is issued.
- Out-of-range block_row/block_col (>MAX) is unspecified; the bench must not drive it.
- ram_address is held at its last value outside READ; it is never written (port a read-only).

Decomposition:
- Package m2_pkg holds:
  - the state enum for m2_block_writer;
  - constants PLANE_WIDTH=320, PLANE_HEIGHT=240, ROW_STRIDE_Y=160, U_OFFSET=38400, V_OFFSET=57600, BLOCK_SAMPLES=64.
- Sub-module clip_u8: combinational signed-32 to unsigned-8 saturation, reused by later milestone blocks.

Test Plan:
- Block (0,0), RAM[k]=k -> 32 writes. Addresses 0,1,2,3,160,...,1123. First word 16'h0001, last word 16'h3E3F. Done in cycle 66.
- Clipping, block (0,0), RAM alternating -5 and 300 -> every written word is 16'h00FF. RAM[0]=255, RAM[1]=256 -> first word 16'hFFFF.
- Last block (29,39) -> first address 232*160+156=37276, last address 239*160+159=38399. Data is unchanged.
- BASE_ADDR=38400 (U plane), block (1,2) -> first address 38400+1280+8=39688.
- Start pulsed in cycle 10 of an active block -> ignored; exactly 32 writes and one Done. Back-to-back Start in the Done cycle -> the second block begins with its first write in cycle 69.
- Resetn low at cycle 20, then high, then Start on block (3,3) -> no write after reset assertion. The new block completes with correct addresses starting at 24*160+12=3852.

Source files
------------

// File: rtl/m2_pkg.sv
// Shared types and plane geometry for the Milestone 2 datapath blocks.
package m2_pkg;

  localparam int unsigned PLANE_WIDTH   = 320;
  localparam int unsigned PLANE_HEIGHT  = 240;
  localparam int unsigned ROW_STRIDE_Y  = 160;
  localparam int unsigned U_OFFSET      = 38400;
  localparam int unsigned V_OFFSET      = 57600;
  localparam int unsigned BLOCK_SAMPLES = 64;

  localparam int unsigned SRAM_AW  = 18;
  localparam int unsigned RAM_AW   = 7;
  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned K_W      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } m2_state_e;

endpackage

// File: rtl/m2_block_writer_if.sv
// Embedded-RAM read port plus SRAM write port seen by the block writer.
interface m2_block_writer_if;
  import m2_pkg::*;

  logic [RAM_AW-1:0]          ram_address;
  logic signed [SAMPLE_W-1:0] ram_read_data;
  logic [SRAM_AW-1:0]         SRAM_address;
  logic [WORD_W-1:0]          SRAM_write_data;
  logic                       SRAM_we_n;

  modport master (
    output ram_address,
    input  ram_read_data,
    output SRAM_address,
    output SRAM_write_data,
    output SRAM_we_n
  );

  modport slave (
    input  ram_address,
    output ram_read_data,
    input  SRAM_address,
    input  SRAM_write_data,
    input  SRAM_we_n
  );

endinterface

// File: rtl/clip_u8.sv
// Saturates a signed 32-bit sample into the unsigned 8-bit pixel range.
module clip_u8
  import m2_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] value,
  output logic [PIX_W-1:0]           clipped_c
);

  // Negative goes to 0, above 255 goes to 255, otherwise pass the low byte.
  always_comb begin
    clipped_c = value[PIX_W-1:0];
    if (value < 32'sd0) begin
      clipped_c = 8'h00;
    end else if (value > 32'sd255) begin
      clipped_c = 8'hFF;
    end
  end

endmodule

// File: rtl/m2_block_writer.sv
// Streams one 8x8 block of samples out of embedded RAM, clips them to pixels
// and writes them as packed pixel pairs to the block's place in the SRAM plane.
module m2_block_writer
  import m2_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] BASE_ADDR  = 18'd0,
  parameter int unsigned        ROW_STRIDE = ROW_STRIDE_Y,
  parameter logic [RAM_AW-1:0]  RAM_BASE   = 7'd0,
  parameter int unsigned        MAX_BROW   = PLANE_HEIGHT / 8 - 1,
  parameter int unsigned        MAX_BCOL   = PLANE_WIDTH / 8 - 1
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Start,
  input  logic [4:0]           block_row,
  input  logic [5:0]           block_col,
  output logic                 Done,
  output logic                 Busy,
  m2_block_writer_if.master    mem
);

  m2_state_e          state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [RAM_AW-1:0]  raddr_q, raddr_d;
  logic [SRAM_AW-1:0] row_base_q, row_base_d;
  logic [PIX_W-1:0]   even_q, even_d;
  logic [SRAM_AW-1:0] saddr_q, saddr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               we_n_q, we_n_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [4:0]         brow_c;
  logic [5:0]         bcol_c;
  logic [SRAM_AW-1:0] start_base_c;
  logic [PIX_W-1:0]   sample_c;

  clip_u8 u_clip (
    .value     (mem.ram_read_data),
    .clipped_c (sample_c)
  );

  // Block indices are held inside the legal range; row base of the block's
  // first pixel row, formed once at Start (constant multiply becomes shift-add).
  always_comb begin
    brow_c = (32'(block_row) > MAX_BROW) ? 5'(MAX_BROW) : block_row;
    bcol_c = (32'(block_col) > MAX_BCOL) ? 6'(MAX_BCOL) : block_col;
    start_base_c = BASE_ADDR
                 + SRAM_AW'(brow_c) * SRAM_AW'(8 * ROW_STRIDE)
                 + (SRAM_AW'(bcol_c) << 2);
  end

  // Next-state and next-output logic; sample k is on ram_read_data while READ holds k.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    raddr_d    = raddr_q;
    row_base_d = row_base_q;
    even_d     = even_q;
    saddr_d    = saddr_q;
    wdata_d    = wdata_q;
    we_n_d     = 1'b1;
    done_d     = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (Start) begin
          state_d    = READ;
          k_d        = '0;
          raddr_d    = RAM_BASE;
          row_base_d = start_base_c;
          busy_d     = 1'b1;
        end
      end

      READ: begin
        if (!k_q[0]) begin
          even_d = sample_c;
        end else begin
          we_n_d  = 1'b0;
          wdata_d = {even_q, sample_c};
          saddr_d = row_base_q + SRAM_AW'(k_q[2:1]);
          // Last pair of a block row: move the base down one image row.
          if (k_q[2:0] == 3'b111) begin
            row_base_d = row_base_q + SRAM_AW'(ROW_STRIDE);
          end
        end
        if (k_q == K_W'(BLOCK_SAMPLES - 1)) begin
          state_d = DRAIN;
        end else begin
          k_d     = k_q + 6'd1;
          raddr_d = RAM_BASE + RAM_AW'(k_q) + 7'd1;
        end
      end

      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      k_q        <= '0;
      raddr_q    <= RAM_BASE;
      row_base_q <= '0;
      even_q     <= '0;
      saddr_q    <= '0;
      wdata_q    <= '0;
      we_n_q     <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      raddr_q    <= raddr_d;
      row_base_q <= row_base_d;
      even_q     <= even_d;
      saddr_q    <= saddr_d;
      wdata_q    <= wdata_d;
      we_n_q     <= we_n_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign Done                = done_q;
  assign Busy                = busy_q;
  assign mem.ram_address     = raddr_q;
  assign mem.SRAM_address    = saddr_q;
  assign mem.SRAM_write_data = wdata_q;
  assign mem.SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_m2_block_writer.sv
// Directed bench for m2_block_writer: RAM model, SRAM write capture, checks.
module tb_m2_block_writer;
  import m2_pkg::*;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start, Start2;
  logic [4:0] block_row, row2;
  logic [5:0] block_col, col2;
  logic       Done, Busy, Done2, Busy2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic signed [31:0] ram [0:127];

  logic [17:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];
  int          dc[$];
  logic [17:0] wa2[$];
  int          nd2 = 0;

  m2_block_writer_if bus ();
  m2_block_writer_if bus2 ();

  // RAM returns the sample for the registered address before the next edge.
  assign bus.ram_read_data  = ram[bus.ram_address];
  assign bus2.ram_read_data = ram[bus2.ram_address];

  m2_block_writer u_dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .block_row (block_row),
    .block_col (block_col),
    .Done      (Done),
    .Busy      (Busy),
    .mem       (bus.master)
  );

  m2_block_writer #(.BASE_ADDR(18'(U_OFFSET))) u_dut_u (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start2),
    .block_row (row2),
    .block_col (col2),
    .Done      (Done2),
    .Busy      (Busy2),
    .mem       (bus2.master)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Capture every SRAM write and Done pulse on the falling edge.
  always @(negedge Clock) begin
    if (bus.SRAM_we_n === 1'b0) begin
      wa.push_back(bus.SRAM_address);
      wd.push_back(bus.SRAM_write_data);
      wc.push_back(cyc);
    end
    if (Done === 1'b1) dc.push_back(cyc);
    if (bus2.SRAM_we_n === 1'b0) wa2.push_back(bus2.SRAM_address);
    if (Done2 === 1'b1) nd2++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_clip(input logic [31:0] v);
    if (v[31]) return 8'h00;
    if (|v[30:8]) return 8'hFF;
    return v[7:0];
  endfunction

  task automatic start_block(input logic [4:0] r, input logic [5:0] c, output int t0);
    @(negedge Clock);
    block_row = r;
    block_col = c;
    Start = 1'b1;
    t0 = cyc;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("done_seen", 32'(at >= 0), 32'd1);
  endtask

  // Compares 32 captured writes against hand-derived plane addresses and data.
  task automatic check_block(input string tag, input int first, input int br, input int bc);
    for (int i = 0; i < 32; i++) begin
      logic [17:0] ea;
      logic [15:0] ed;
      ea = 18'((br * 8 + i / 4) * 160 + bc * 4 + i % 4);
      ed = {ref_clip(ram[2 * i]), ref_clip(ram[2 * i + 1])};
      chk({tag, "_addr"}, 32'(wa[first + i]), 32'(ea));
      chk({tag, "_data"}, 32'(wd[first + i]), 32'(ed));
      chk({tag, "_spacing"}, 32'(wc[first + i] - wc[first]), 32'(2 * i));
    end
  endtask

  initial begin
    int t0, t1, at, at2, n0, n1, d0, nr;

    Resetn = 1'b0;
    Start = 1'b0;  Start2 = 1'b0;
    block_row = '0; block_col = '0;
    row2 = '0;      col2 = '0;
    for (int k = 0; k < 128; k++) ram[k] = 32'(k);

    // Reset state
    repeat (2) @(negedge Clock);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ram_address", 32'(bus.ram_address), 32'd0);
    chk("rst_sram_address", 32'(bus.SRAM_address), 32'd0);
    chk("rst_sram_data", 32'(bus.SRAM_write_data), 32'd0);
    chk("rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
    Resetn = 1'b1;
    @(negedge Clock);

    // Block (0,0) with RAM[k]=k
    n0 = wa.size(); d0 = dc.size();
    start_block(5'd0, 6'd0, t0);
    chk("a_ram_addr_c1", 32'(bus.ram_address), 32'd0);
    chk("a_busy_c1", 32'(Busy), 32'd1);
    wait_done(at);
    chk("a_done_cycle", 32'(at - t0), 32'd66);
    chk("a_busy_at_done", 32'(Busy), 32'd0);
    repeat (3) @(negedge Clock);
    chk("a_done_count", 32'(dc.size() - d0), 32'd1);
    chk("a_done_width", 32'(Done), 32'd0);
    chk("a_write_count", 32'(wa.size() - n0), 32'd32);
    chk("a_first_cycle", 32'(wc[n0] - t0), 32'd3);
    chk("a_last_cycle", 32'(wc[n0 + 31] - t0), 32'd65);
    chk("a_addr0", 32'(wa[n0]), 32'd0);
    chk("a_addr3", 32'(wa[n0 + 3]), 32'd3);
    chk("a_addr4", 32'(wa[n0 + 4]), 32'd160);
    chk("a_addr_last", 32'(wa[n0 + 31]), 32'd1123);
    chk("a_data0", 32'(wd[n0]), 32'h0001);
    chk("a_data_last", 32'(wd[n0 + 31]), 32'h3E3F);
    check_block("a", n0, 0, 0);

    // Clipping
    for (int k = 0; k < 64; k++) ram[k] = (k % 2 == 0) ? -32'sd5 : 32'sd300;
    ram[0] = 32'sd255;        ram[1] = 32'sd256;
    ram[4] = 32'sd127;        ram[5] = 32'sh8000_0000;
    ram[6] = 32'sh7FFF_FFFF;  ram[7] = 32'sd0;
    n0 = wa.size();
    start_block(5'd0, 6'd0, t0);
    wait_done(at);
    repeat (2) @(negedge Clock);
    chk("b_write_count", 32'(wa.size() - n0), 32'd32);
    chk("b_word0", 32'(wd[n0]), 32'hFFFF);
    chk("b_word1", 32'(wd[n0 + 1]), 32'h00FF);
    chk("b_word2", 32'(wd[n0 + 2]), 32'h7F00);
    chk("b_word3", 32'(wd[n0 + 3]), 32'hFF00);
    chk("b_word20", 32'(wd[n0 + 20]), 32'h00FF);
    check_block("b", n0, 0, 0);

    // Last block of the plane
    for (int k = 0; k < 64; k++) ram[k] = 32'(k);
    n0 = wa.size();
    start_block(5'd29, 6'd39, t0);
    wait_done(at);
    repeat (2) @(negedge Clock);
    chk("c_write_count", 32'(wa.size() - n0), 32'd32);
    chk("c_addr_first", 32'(wa[n0]), 32'd37276);
    chk("c_addr_last", 32'(wa[n0 + 31]), 32'd38399);
    chk("c_data_last", 32'(wd[n0 + 31]), 32'h3E3F);
    check_block("c", n0, 29, 39);

    // U-plane instance, block (1,2)
    n0 = wa2.size(); d0 = nd2;
    @(negedge Clock);
    row2 = 5'd1; col2 = 6'd2; Start2 = 1'b1;
    @(negedge Clock);
    Start2 = 1'b0;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (Done2 === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("d_done_seen", 32'(at >= 0), 32'd1);
    repeat (2) @(negedge Clock);
    chk("d_done_count", 32'(nd2 - d0), 32'd1);
    chk("d_write_count", 32'(wa2.size() - n0), 32'd32);
    chk("d_addr_first", 32'(wa2[n0]), 32'd39688);
    chk("d_addr_last", 32'(wa2[n0 + 31]), 32'd40811);

    // Stray Start mid-block, then back-to-back Start in the Done cycle
    n0 = wa.size(); d0 = dc.size();
    start_block(5'd0, 6'd0, t0);
    repeat (9) @(negedge Clock);
    block_row = 5'd5; block_col = 6'd5; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(at);
    chk("e_done_cycle", 32'(at - t0), 32'd66);
    block_row = 5'd2; block_col = 6'd1; Start = 1'b1;
    t1 = cyc;
    n1 = wa.size();
    @(negedge Clock);
    Start = 1'b0;
    chk("e_first_count", 32'(n1 - n0), 32'd32);
    check_block("e1", n0, 0, 0);
    wait_done(at2);
    chk("e2_done_cycle", 32'(at2 - t1), 32'd66);
    repeat (2) @(negedge Clock);
    chk("e_done_count", 32'(dc.size() - d0), 32'd2);
    chk("e2_write_count", 32'(wa.size() - n1), 32'd32);
    chk("e2_first_cycle", 32'(wc[n1] - t0), 32'd69);
    chk("e2_addr_first", 32'(wa[n1]), 32'd2564);
    check_block("e2", n1, 2, 1);

    // Reset in the middle of a block
    n0 = wa.size(); d0 = dc.size();
    start_block(5'd0, 6'd0, t0);
    repeat (19) @(negedge Clock);
    nr = wa.size();
    chk("f_writes_before_rst", 32'(nr - n0), 32'd9);
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    chk("f_rst_we_n", 32'(bus.SRAM_we_n), 32'd1);
    chk("f_rst_busy", 32'(Busy), 32'd0);
    chk("f_rst_done", 32'(Done), 32'd0);
    chk("f_rst_ram_addr", 32'(bus.ram_address), 32'd0);
    Resetn = 1'b1;
    repeat (4) @(negedge Clock);
    chk("f_no_write_after_rst", 32'(wa.size() - nr), 32'd0);
    chk("f_no_done_after_rst", 32'(dc.size() - d0), 32'd0);
    start_block(5'd3, 6'd3, t0);
    wait_done(at);
    chk("f_done_cycle", 32'(at - t0), 32'd66);
    repeat (2) @(negedge Clock);
    chk("f_write_count", 32'(wa.size() - nr), 32'd32);
    chk("f_addr_first", 32'(wa[nr]), 32'd3852);
    chk("f_addr_last", 32'(wa[nr + 31]), 32'd4975);
    check_block("f", nr, 3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
